video_int_gen: RTL

Raster interrupt generator for the TS-Conf video path. It tracks the beam position as a horizontal step count and a line count. It compares that position against `hint_beg`/`vint_beg` from the video port register file and returns a one-clock `int_start` to that file so it can advance `vint_beg`. It also drives the Z80 `/INT` line with frame and line interrupts, a timed pulse width, acknowledge handling and a priority vector.

---
 rtl/video_int_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/video_int_gen.sv
// Raster interrupt generator: beam position compare, /INT pulse, ack, vector.
// Line interrupts are built only when VIDEO_LINE_INT_EN is defined.
module video_int_gen #(
  parameter int unsigned INT_LEN = 32
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic       hstep,
  input  logic [7:0] hint_beg,
  input  logic [8:0] vint_beg,
  input  logic [1:0] intmask,
  input  logic       int_ack,
  output logic       int_start,
  output logic       int_n,
  output logic [7:0] int_vec,
  output logic [1:0] int_pend
);

  localparam logic [7:0] LEN = 8'(INT_LEN);

  logic [7:0] hcnt;
  logic [8:0] vcnt;
  logic       fired;
  logic [1:0] pend;
  logic [7:0] tcnt;

  logic       hit;
  logic       frame_hit;
  logic [1:0] mask;
  logic [1:0] set;
  logic [1:0] nx;
  logic       ack_f;
  logic       ack_l;
  logic       rise;

`ifdef VIDEO_LINE_INT_EN
  assign mask = intmask;
`else
  logic unused_mask;
  assign unused_mask = intmask[1];
  assign mask = {1'b0, intmask[0]};
`endif

  // A frame set redirects a simultaneous ack to the line source.
  always_comb begin
    hit       = (hcnt == hint_beg) && !fired && !line_start;
    frame_hit = hit && (vcnt == vint_beg);
    set       = {hit & mask[1], frame_hit & mask[0]};
    ack_f     = int_ack & pend[0] & ~set[0];
    ack_l     = int_ack & (set[0] | (~pend[0] & ~set[1]));
    nx[0]     = ((pend[0] & ~ack_f) | set[0]) & mask[0];
    nx[1]     = ((pend[1] | set[1]) & ~ack_l) & mask[1];
    rise      = |(nx & ~pend);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      fired     <= 1'b0;
      pend      <= '0;
      tcnt      <= '0;
      int_start <= 1'b0;
    end else begin
      if (line_start)
        hcnt <= '0;
      else if (hstep && hcnt != 8'hff)
        hcnt <= hcnt + 8'd1;

      if (frame_start)
        vcnt <= '0;
      else if (line_start && vcnt != 9'h1ff)
        vcnt <= vcnt + 9'd1;

      if (line_start)
        fired <= 1'b0;
      else if (hit)
        fired <= 1'b1;

      int_start <= frame_hit;

      if (rise) begin
        pend <= nx;
        tcnt <= LEN;
      end else if (tcnt != 8'd0 && |pend) begin
        tcnt <= tcnt - 8'd1;
        pend <= (tcnt == 8'd1) ? 2'b00 : nx;
      end else begin
        pend <= nx;
      end
    end
  end

  assign int_n    = ~|pend;
  assign int_pend = pend;

`ifdef VIDEO_LINE_INT_EN
  always_comb begin
    int_vec = 8'hff;
    if (!pend[0] && pend[1])
      int_vec = 8'hfd;
  end
`else
  assign int_vec = 8'hff;
`endif

endmodule
